// File: rtl/req_tag_alloc_if.sv
// Request/issue/completion bundle for the tag allocator.
// master: request/completion source; slave: allocator.
interface req_tag_alloc_if #(
  parameter int TAG_WIDTH = 3,
  parameter int HIS_WIDTH = 4,
  parameter int CNT_WIDTH = 4
);
  localparam int HW = (HIS_WIDTH == 0) ? 1 : HIS_WIDTH;

  logic                 req_vld;
  logic                 req_rdy;
  logic [HW-1:0]        req_his;
  logic                 iss_vld;
  logic                 iss_rdy;
  logic [TAG_WIDTH-1:0] iss_tag;
  logic [HW-1:0]        iss_his;
  logic                 cpl_vld;
  logic [TAG_WIDTH-1:0] cpl_tag;
  logic                 cpl_last;
  logic                 err_spur;
  logic                 to_vld;
  logic [TAG_WIDTH-1:0] to_tag;
  logic [CNT_WIDTH-1:0] outstanding;

  modport master (
    output req_vld, req_his, iss_rdy,
    output cpl_vld, cpl_tag, cpl_last,
    input  req_rdy, iss_vld, iss_tag, iss_his,
    input  err_spur, to_vld, to_tag, outstanding
  );

  modport slave (
    input  req_vld, req_his, iss_rdy,
    input  cpl_vld, cpl_tag, cpl_last,
    output req_rdy, iss_vld, iss_tag, iss_his,
    output err_spur, to_vld, to_tag, outstanding
  );
endinterface

// File: rtl/req_tag_alloc.sv
// Request tag allocator: lowest-free tag issue, completion free, timeouts.
// Ports: clk, rst (async, active-high), bus (req_tag_alloc_if.slave).
module req_tag_alloc #(
  parameter int TAG_COUNT = 8,
  parameter int HIS_WIDTH = 4,
  parameter int TAG_WIDTH = $clog2(TAG_COUNT),
  parameter int CNT_WIDTH = $clog2(TAG_COUNT + 1),
  parameter int TO_WIDTH  = 10,
  parameter int TIMEOUT   = 1023
) (
  input logic           clk,
  input logic           rst,
  req_tag_alloc_if.slave bus
);
  localparam int HW = (HIS_WIDTH == 0) ? 1 : HIS_WIDTH;

  logic [TAG_COUNT-1:0] busy;
  logic [TAG_COUNT-1:0] pend;
  logic [TAG_COUNT-1:0] busy_nxt;
  logic [TAG_COUNT-1:0] pend_nxt;
  logic [TAG_COUNT-1:0] pend_eff;
  logic [TAG_COUNT-1:0] alloc_m;
  logic [TAG_COUNT-1:0] cpl_m;
  logic [TAG_COUNT-1:0] rep_m;
  logic [TAG_COUNT-1:0] free_m;
  logic [TO_WIDTH-1:0]  cnt [TAG_COUNT];

  logic                 any_free;
  logic                 req_rdy;
  logic                 accept;
  logic                 cpl_hit;
  logic                 rep_any;
  logic [TAG_WIDTH-1:0] free_idx;
  logic [TAG_WIDTH-1:0] rep_idx;
  logic [CNT_WIDTH-1:0] pop;

  logic                 iss_vld_q;
  logic [TAG_WIDTH-1:0] iss_tag_q;
  logic [HW-1:0]        iss_his_q;
  logic                 err_q;
  logic                 to_vld_q;
  logic [TAG_WIDTH-1:0] to_tag_q;
  logic [CNT_WIDTH-1:0] out_q;

  always_comb begin
    any_free = ~&busy;
    req_rdy  = any_free && (!iss_vld_q || bus.iss_rdy);
    accept   = bus.req_vld && req_rdy;

    free_idx = '0;
    for (int i = TAG_COUNT - 1; i >= 0; i--)
      if (!busy[i]) free_idx = TAG_WIDTH'(i);

    alloc_m = '0;
    if (accept) alloc_m[free_idx] = 1'b1;

    cpl_hit = bus.cpl_vld && busy[bus.cpl_tag];
    cpl_m   = '0;
    if (cpl_hit) cpl_m[bus.cpl_tag] = 1'b1;

    // A completion in the same cycle beats a pending timeout.
    pend_eff = pend & ~cpl_m;
    rep_any  = |pend_eff;
    rep_idx  = '0;
    for (int i = TAG_COUNT - 1; i >= 0; i--)
      if (pend_eff[i]) rep_idx = TAG_WIDTH'(i);
    rep_m = '0;
    if (rep_any) rep_m[rep_idx] = 1'b1;

    free_m   = rep_m | (bus.cpl_last ? cpl_m : '0);
    busy_nxt = (busy & ~free_m) | alloc_m;

    pend_nxt = '0;
    for (int t = 0; t < TAG_COUNT; t++)
      pend_nxt[t] = busy[t] && !free_m[t] && !cpl_m[t] &&
                    (pend[t] || ((TIMEOUT != 0) &&
                     cnt[t] == TO_WIDTH'(TIMEOUT - 1)));

    pop = '0;
    for (int i = 0; i < TAG_COUNT; i++)
      pop = pop + CNT_WIDTH'(busy_nxt[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < TAG_COUNT; t++) cnt[t] <= '0;
    end else begin
      for (int t = 0; t < TAG_COUNT; t++) begin
        if (alloc_m[t] || cpl_m[t] || free_m[t])
          cnt[t] <= '0;
        else if (busy[t] && (TIMEOUT != 0) &&
                 cnt[t] != TO_WIDTH'(TIMEOUT))
          cnt[t] <= cnt[t] + TO_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= '0;
      pend      <= '0;
      iss_vld_q <= 1'b0;
      iss_tag_q <= '0;
      iss_his_q <= '0;
      err_q     <= 1'b0;
      to_vld_q  <= 1'b0;
      to_tag_q  <= '0;
      out_q     <= '0;
    end else begin
      busy     <= busy_nxt;
      pend     <= pend_nxt;
      out_q    <= pop;
      err_q    <= bus.cpl_vld && !busy[bus.cpl_tag];
      to_vld_q <= rep_any;
      if (rep_any) to_tag_q <= rep_idx;
      if (accept) begin
        iss_vld_q <= 1'b1;
        iss_tag_q <= free_idx;
        iss_his_q <= bus.req_his;
      end else if (bus.iss_rdy) begin
        iss_vld_q <= 1'b0;
      end
    end
  end

  assign bus.req_rdy     = req_rdy;
  assign bus.iss_vld     = iss_vld_q;
  assign bus.iss_tag     = iss_tag_q;
  assign bus.iss_his     = iss_his_q;
  assign bus.err_spur    = err_q;
  assign bus.to_vld      = to_vld_q;
  assign bus.to_tag      = to_tag_q;
  assign bus.outstanding = out_q;
endmodule

// File: tb/tb_req_tag_alloc.sv
// Directed bench for req_tag_alloc (TIMEOUT=16).
// Vector table for issue/full/stall, hand sequences for timeouts.
module tb_req_tag_alloc;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  req_tag_alloc_if #(.TAG_WIDTH(3), .HIS_WIDTH(4), .CNT_WIDTH(4)) bus ();

  req_tag_alloc #(.TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       rst;
    logic       rv;
    logic [3:0] his;
    logic       ir;
    logic       cv;
    logic [2:0] ct;
    logic       cl;
    logic       e_rdy;
    logic       e_iv;
    logic [2:0] e_tag;
    logic [3:0] e_his;
    logic [3:0] e_out;
  } vec_t;

  vec_t tbl [32];
  int   n_vec = 0;
  int   checks = 0;
  int   errors = 0;
  int   err_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic put(input logic r, input logic rv, input logic [3:0] h,
                     input logic ir, input logic cv, input logic [2:0] ct,
                     input logic cl, input logic erdy, input logic eiv,
                     input logic [2:0] etag, input logic [3:0] ehis,
                     input logic [3:0] eout);
    tbl[n_vec] = '{r, rv, h, ir, cv, ct, cl, erdy, eiv, etag, ehis, eout};
    n_vec++;
  endtask

  task automatic idle_in();
    bus.req_vld  = 1'b0;
    bus.req_his  = '0;
    bus.iss_rdy  = 1'b1;
    bus.cpl_vld  = 1'b0;
    bus.cpl_tag  = '0;
    bus.cpl_last = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.err_spur === 1'b1) err_seen++;
  endtask

  task automatic do_reset();
    idle_in();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_iss_vld", 32'(bus.iss_vld), 0);
    chk("rst_out", 32'(bus.outstanding), 0);
    chk("rst_to_vld", 32'(bus.to_vld), 0);
    chk("rst_err", 32'(bus.err_spur), 0);
    chk("rst_tags", 32'({bus.iss_tag, bus.iss_his, bus.to_tag}), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit found;
    int waited;
    logic seen_to, seen_err;

    // test 1: 8 back-to-back issues, then full
    for (int k = 0; k < 8; k++)
      put(k == 0, 1, 4'(k + 3), 1, 0, 0, 0,
          1, 1, 3'(k), 4'(k + 3), 4'(k + 1));
    put(0, 1, 4'hF, 1, 0, 0, 0, 0, 0, 3'd7, 4'hA, 4'd8);
    // test 2: free tag 5, reissue it next cycle
    put(0, 0, 4'h0, 1, 1, 3'd5, 1, 0, 0, 3'd7, 4'hA, 4'd7);
    put(0, 1, 4'h9, 1, 0, 0, 0, 1, 1, 3'd5, 4'h9, 4'd8);
    put(0, 1, 4'h2, 1, 0, 0, 0, 0, 0, 3'd5, 4'h9, 4'd8);
    // test 3: downstream stall holds the issue stage
    put(1, 1, 4'hA, 0, 0, 0, 0, 1, 1, 3'd0, 4'hA, 4'd1);
    for (int k = 0; k < 4; k++)
      put(0, 1, 4'hB, 0, 0, 0, 0, 0, 1, 3'd0, 4'hA, 4'd1);
    put(0, 0, 4'h0, 1, 0, 0, 0, 1, 0, 3'd0, 4'hA, 4'd1);

    idle_in();
    for (int i = 0; i < n_vec; i++) begin
      if (tbl[i].rst) do_reset();
      bus.req_vld  = tbl[i].rv;
      bus.req_his  = tbl[i].his;
      bus.iss_rdy  = tbl[i].ir;
      bus.cpl_vld  = tbl[i].cv;
      bus.cpl_tag  = tbl[i].ct;
      bus.cpl_last = tbl[i].cl;
      #3;
      chk($sformatf("v%0d_req_rdy", i), 32'(bus.req_rdy), 32'(tbl[i].e_rdy));
      tick();
      chk($sformatf("v%0d_iss_vld", i), 32'(bus.iss_vld), 32'(tbl[i].e_iv));
      chk($sformatf("v%0d_iss_tag", i), 32'(bus.iss_tag), 32'(tbl[i].e_tag));
      chk($sformatf("v%0d_iss_his", i), 32'(bus.iss_his), 32'(tbl[i].e_his));
      chk($sformatf("v%0d_out", i), 32'(bus.outstanding), 32'(tbl[i].e_out));
      chk($sformatf("v%0d_err", i), 32'(bus.err_spur), 0);
      chk($sformatf("v%0d_to", i), 32'(bus.to_vld), 0);
    end

    // test 4: two tags time out on consecutive cycles
    do_reset();
    bus.req_vld = 1'b1;
    bus.req_his = 4'h1;
    tick();
    bus.req_his = 4'h2;
    tick();
    chk("t4_tag1", 32'(bus.iss_tag), 1);
    bus.req_vld = 1'b0;
    waited = 1;
    for (int k = 0; k < 40; k++) begin
      tick();
      waited++;
      if (bus.to_vld) break;
    end
    chk("t4_latency", 32'(waited), 17);
    chk("t4_to_tag0", 32'(bus.to_tag), 0);
    chk("t4_out1", 32'(bus.outstanding), 1);
    tick();
    chk("t4_to_vld1", 32'(bus.to_vld), 1);
    chk("t4_to_tag1", 32'(bus.to_tag), 1);
    chk("t4_out0", 32'(bus.outstanding), 0);
    tick();
    chk("t4_to_done", 32'(bus.to_vld), 0);

    // test 5: partial completions keep tag 2 alive
    do_reset();
    bus.req_vld = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.req_his = 4'(k);
      tick();
    end
    chk("t5_tag2", 32'(bus.iss_tag), 2);
    bus.req_vld  = 1'b0;
    bus.cpl_vld  = 1'b1;
    bus.cpl_last = 1'b1;
    bus.cpl_tag  = 3'd0;
    tick();
    bus.cpl_tag  = 3'd1;
    tick();
    bus.cpl_last = 1'b0;
    bus.cpl_tag  = 3'd2;
    chk("t5_out1", 32'(bus.outstanding), 1);
    seen_to  = 1'b0;
    seen_err = 1'b0;
    for (int k = 0; k < 40; k++) begin
      bus.cpl_vld = (k % 10 == 0);
      tick();
      seen_to  = seen_to | bus.to_vld;
      seen_err = seen_err | bus.err_spur;
    end
    chk("t5_no_to", 32'(seen_to), 0);
    chk("t5_no_err", 32'(seen_err), 0);
    chk("t5_out_hold", 32'(bus.outstanding), 1);
    bus.cpl_vld  = 1'b1;
    bus.cpl_last = 1'b1;
    tick();
    bus.cpl_vld  = 1'b0;
    chk("t5_out_free", 32'(bus.outstanding), 0);
    chk("t5_err", 32'(bus.err_spur), 0);

    // test 6: spurious completions
    do_reset();
    err_seen = 0;
    bus.cpl_vld = 1'b1;
    bus.cpl_tag = 3'd3;
    tick();
    bus.cpl_vld = 1'b0;
    chk("t6_err_idle", 32'(bus.err_spur), 1);
    chk("t6_out_idle", 32'(bus.outstanding), 0);
    tick();
    chk("t6_err_pulse", 32'(bus.err_spur), 0);
    bus.req_vld = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    bus.req_vld = 1'b0;
    chk("t6_out5", 32'(bus.outstanding), 5);
    found = 1'b0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (bus.to_vld && bus.to_tag == 3'd4) begin
        found = 1'b1;
        break;
      end
    end
    chk("t6_to_tag4", 32'(found), 1);
    chk("t6_out_to", 32'(bus.outstanding), 0);
    bus.cpl_vld  = 1'b1;
    bus.cpl_last = 1'b1;
    bus.cpl_tag  = 3'd4;
    tick();
    bus.cpl_vld  = 1'b0;
    bus.cpl_last = 1'b0;
    chk("t6_err_late", 32'(bus.err_spur), 1);
    chk("t6_out_late", 32'(bus.outstanding), 0);
    tick();
    chk("t6_err_count", 32'(err_seen), 2);
    bus.req_vld = 1'b1;
    tick();
    bus.req_vld = 1'b0;
    chk("t6_realloc_tag", 32'(bus.iss_tag), 0);
    chk("t6_realloc_out", 32'(bus.outstanding), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
